// File: rtl/seg_scan.sv
//==============================================================================
// Module      : seg_scan
// Description : Multiplexed 7-segment scan driver with double-buffered settings,
//               PWM brightness and leading-zero blanking. The optional macro
//               SEG_ACTIVE_LOW_EN inverts seg/seg_dp/an for common-anode boards.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg_scan #(
    parameter int N_DIG    = 8,
    parameter int PRESCALE = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [4*N_DIG-1:0]       num,
    input  logic [$clog2(N_DIG)-1:0] dp,
    input  logic                     dp_en,
    input  logic                     lz_blank,
    input  logic [1:0]               bright,
    output logic [6:0]               seg,
    output logic                     seg_dp,
    output logic [N_DIG-1:0]         an,
    output logic                     load_ack,
    output logic                     frame
);
    localparam int c_cnt_w = $clog2(PRESCALE);
    localparam int c_idx_w = $clog2(N_DIG);
    localparam int c_qtr   = PRESCALE / 4;
    localparam logic [c_cnt_w:0] c_lim0 = (c_cnt_w+1)'(c_qtr);
    localparam logic [c_cnt_w:0] c_lim1 = (c_cnt_w+1)'(2 * c_qtr);
    localparam logic [c_cnt_w:0] c_lim2 = (c_cnt_w+1)'(3 * c_qtr);
    localparam logic [c_cnt_w:0] c_lim3 = (c_cnt_w+1)'(PRESCALE);
`ifdef SEG_ACTIVE_LOW_EN
    localparam logic c_inv = 1'b1;
`else
    localparam logic c_inv = 1'b0;
`endif

    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [c_idx_w-1:0] idx_q, idx_d;
    logic               pending_q, pending_d;
    logic [4*N_DIG-1:0] sh_num_q, sh_num_d, act_num_q, act_num_d;
    logic [c_idx_w-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic               sh_dp_en_q, sh_dp_en_d, act_dp_en_q, act_dp_en_d;
    logic               sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
    logic [1:0]         sh_bright_q, sh_bright_d, act_bright_q, act_bright_d;
    logic [6:0]         seg_q, seg_d;
    logic               seg_dp_q, seg_dp_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               load_ack_q, load_ack_d;
    logic               frame_q, frame_d;

    logic               wrap, boundary, lit, all_zero, keep;
    logic [N_DIG-1:0]   blank_mask;
    logic [c_cnt_w:0]   on_lim;
    logic [3:0]         cur_nib;
    logic [6:0]         glyph;

    always_comb begin
        wrap     = (cnt_q == (c_cnt_w)'(PRESCALE - 1));
        boundary = wrap && (idx_q == (c_idx_w)'(N_DIG - 1));
        cnt_d    = wrap ? '0 : cnt_q + (c_cnt_w)'(1);
        idx_d    = idx_q;
        if (wrap) begin
            idx_d = (idx_q == (c_idx_w)'(N_DIG - 1)) ? '0 : idx_q + (c_idx_w)'(1);
        end

        // A load coinciding with a boundary stays pending; the transfer uses the old shadow.
        sh_num_d    = load ? num      : sh_num_q;
        sh_dp_d     = load ? dp       : sh_dp_q;
        sh_dp_en_d  = load ? dp_en    : sh_dp_en_q;
        sh_lz_d     = load ? lz_blank : sh_lz_q;
        sh_bright_d = load ? bright   : sh_bright_q;
        pending_d   = load ? 1'b1 : (boundary ? 1'b0 : pending_q);

        act_num_d    = act_num_q;
        act_dp_d     = act_dp_q;
        act_dp_en_d  = act_dp_en_q;
        act_lz_d     = act_lz_q;
        act_bright_d = act_bright_q;
        if (boundary && pending_q) begin
            act_num_d    = sh_num_q;
            act_dp_d     = sh_dp_q;
            act_dp_en_d  = sh_dp_en_q;
            act_lz_d     = sh_lz_q;
            act_bright_d = sh_bright_q;
        end
        load_ack_d = boundary && pending_q;
        frame_d    = boundary;
    end

    // Walk down from the MSD: a digit is a leading zero while everything above it is zero.
    always_comb begin
        all_zero   = 1'b1;
        keep       = 1'b0;
        blank_mask = '0;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            all_zero      = all_zero && (act_num_q[4*k +: 4] == 4'd0);
            keep          = (k == 0) || (act_dp_en_q && ((c_idx_w)'(k) <= act_dp_q));
            blank_mask[k] = act_lz_q && all_zero && !keep;
        end
    end

    always_comb begin
        cur_nib = act_num_q[{idx_q, 2'b00} +: 4];
        case (cur_nib)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h40;
            4'hE:    glyph = 7'h79;
            default: glyph = 7'h00;
        endcase

        case (act_bright_q)
            2'd0:    on_lim = c_lim0;
            2'd1:    on_lim = c_lim1;
            2'd2:    on_lim = c_lim2;
            default: on_lim = c_lim3;
        endcase
        lit = ({1'b0, cnt_q} < on_lim);

        an_d     = {N_DIG{c_inv}} ^ (lit ? ((N_DIG)'(1) << idx_q) : '0);
        seg_d    = {7{c_inv}} ^ ((lit && !blank_mask[idx_q]) ? glyph : 7'h00);
        seg_dp_d = c_inv ^ (lit && act_dp_en_q && (idx_q == act_dp_q));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            sh_num_q     <= '0;
            sh_dp_q      <= '0;
            sh_dp_en_q   <= 1'b0;
            sh_lz_q      <= 1'b0;
            sh_bright_q  <= 2'd3;
            act_num_q    <= '0;
            act_dp_q     <= '0;
            act_dp_en_q  <= 1'b0;
            act_lz_q     <= 1'b0;
            act_bright_q <= 2'd3;
            seg_q        <= {7{c_inv}};
            seg_dp_q     <= c_inv;
            an_q         <= {N_DIG{c_inv}};
            load_ack_q   <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            sh_num_q     <= sh_num_d;
            sh_dp_q      <= sh_dp_d;
            sh_dp_en_q   <= sh_dp_en_d;
            sh_lz_q      <= sh_lz_d;
            sh_bright_q  <= sh_bright_d;
            act_num_q    <= act_num_d;
            act_dp_q     <= act_dp_d;
            act_dp_en_q  <= act_dp_en_d;
            act_lz_q     <= act_lz_d;
            act_bright_q <= act_bright_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            an_q         <= an_d;
            load_ack_q   <= load_ack_d;
            frame_q      <= frame_d;
        end
    end

    assign seg      = seg_q;
    assign seg_dp   = seg_dp_q;
    assign an       = an_q;
    assign load_ack = load_ack_q;
    assign frame    = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
//==============================================================================
// Module      : tb_seg_scan
// Description : Scoreboard bench for seg_scan (PRESCALE=4). Stimulus pushes the
//               expected slot displays and load_ack values; a monitor pops them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seg_scan;
    localparam int N_DIG    = 8;
    localparam int PRESCALE = 4;
`ifdef SEG_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] num = '0;
    logic [2:0]  dp = '0;
    logic        dp_en = 1'b0;
    logic        lz_blank = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [7:0]  an;
    logic        load_ack;
    logic        frame;
    logic [7:0]  an_l;
    logic [6:0]  seg_l;
    logic        dp_l;

    slot_t slot_q[$];
    logic  ack_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    seg_scan #(.N_DIG(N_DIG), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .load(load), .num(num), .dp(dp), .dp_en(dp_en),
        .lz_blank(lz_blank), .bright(bright), .seg(seg), .seg_dp(seg_dp), .an(an),
        .load_ack(load_ack), .frame(frame)
    );

    always #5 clk = ~clk;

    assign an_l  = an ^ {8{INV}};
    assign seg_l = seg ^ {7{INV}};
    assign dp_l  = seg_dp ^ INV;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_slot(input logic [7:0] a, input logic [6:0] s, input logic d);
        slot_t e;
        e.an = a; e.seg = s; e.dp = d;
        slot_q.push_back(e);
    endtask

    // segs packed {d7,...,d0}; slots are expected in scan order 0..7
    task automatic push_frame8(input logic [55:0] segs, input logic [7:0] dps);
        for (int k = 0; k < 8; k++) push_slot(8'(1 << k), segs[7*k +: 7], dps[k]);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame && k < 100);
        if (!frame) check("frame_timeout", 32'd0, 32'd1);
    endtask

    // Counts lit cycles over the 32 samples of one frame; optionally pulses load early on.
    task automatic measure_frame(input logic do_load, input int exp_on, input string name);
        int on;
        on = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (do_load && i == 2) load = 1'b1;
            if (do_load && i == 3) begin
                load = 1'b0;
                ack_q.push_back(1'b1);
            end
            if (an_l != 8'h00) on++;
        end
        check(name, 32'(on), 32'(exp_on));
    endtask

    initial begin : monitor
        logic [7:0] prev;
        slot_t      e;
        logic       a;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            if (frame && ack_q.size() > 0) begin
                a = ack_q.pop_front();
                check("load_ack", 32'(load_ack), 32'(a));
            end
            if (an_l != 8'h00 && an_l != prev && slot_q.size() > 0) begin
                e = slot_q.pop_front();
                check("slot_an", 32'(an_l), 32'(e.an));
                check("slot_seg", 32'(seg_l), 32'(e.seg));
                check("slot_dp", 32'(dp_l), 32'(e.dp));
            end
            prev = an_l;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // 1. reset state, then free-running scan of all zeros
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", 32'(an), 32'({8{INV}}));
        check("rst_seg", 32'(seg), 32'({7{INV}}));
        check("rst_dp", 32'(seg_dp), 32'(INV));
        check("rst_ack", 32'(load_ack), 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        push_frame8({8{7'h3F}}, 8'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("first_an", 32'(an_l), 32'h01);
        check("first_seg", 32'(seg_l), 32'h3F);
        wait_frame();

        // 2. load 1234 with blanking; takes effect at the next frame boundary
        num = 32'h0000_1234; lz_blank = 1'b1; bright = 2'd3; dp_en = 1'b0; dp = 3'd0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ack_q.push_back(1'b1);
        wait_frame();
        push_frame8({7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66}, 8'h00);

        // 3. brightness change lands only after load_ack
        bright = 2'd0;
        measure_frame(1'b1, 32, "duty_b3_before_ack");
        push_frame8({7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66}, 8'h00);
        measure_frame(1'b0, 8, "duty_b0");

        // 4. two loads in one frame: last wins, single ack
        bright = 2'd3; num = 32'h1;
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0; num = 32'h2;
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        ack_q.push_back(1'b1);
        ack_q.push_back(1'b0);
        wait_frame();
        push_frame8({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h5B}, 8'h00);
        wait_frame();

        // 4b. load in the boundary cycle: ack one frame later
        repeat (31) @(negedge clk);
        ack_q.push_back(1'b0);
        ack_q.push_back(1'b1);
        num = 32'h3; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("frame_at_boundary_load", 32'(frame), 32'd1);
        wait_frame();
        push_frame8({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h4F}, 8'h00);
        wait_frame();

        // 5. decimal point protects lower zeros from blanking
        @(negedge clk);
        num = 32'h5; dp = 3'd2; dp_en = 1'b1; lz_blank = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ack_q.push_back(1'b1);
        wait_frame();
        push_frame8({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h6D}, 8'h04);
        wait_frame();

        // 6. reset mid-slot discards the pending load
        repeat (5) @(negedge clk);
        num = 32'h99; dp_en = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'({8{INV}}));
        check("midrst_seg", 32'(seg), 32'({7{INV}}));
        check("midrst_dp", 32'(seg_dp), 32'(INV));
        check("midrst_ack", 32'(load_ack), 32'd0);
        check("midrst_frame", 32'(frame), 32'd0);
        push_frame8({8{7'h3F}}, 8'h00);
        ack_q.push_back(1'b0);
        ack_q.push_back(1'b0);
        @(negedge clk);
        rst = 1'b1;
        wait_frame();
        wait_frame();
        @(negedge clk);
        check("slot_queue_drained", 32'(slot_q.size()), 32'd0);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
